ram_loader: RTL

- Upstream program loader for the 16-byte RAM.
- Takes a byte stream from a UART receiver via a valid/ready handshake and writes a framed program image into RAM through its port (synchronous write, 1-cycle registered read).
- Reads the image back to verify it, then reports done or error.
- Holds the CPU halted for the whole load.

---
 rtl/ram_loader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Framed program loader: SYNC, LEN, LEN data bytes, CSUM -> RAM write, readback verify.
// Optional inter-byte timeout is built when LOADER_TIMEOUT_EN is defined.
module ram_loader #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cpu_halt,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            error_code
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] DEPTH_D = DATA_WIDTH'(RAM_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_VERIFY = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         len_q, len_d, idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d, csum_q, csum_d, rsum_q, rsum_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  halt_q, halt_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  accept;
  logic [CW-1:0]         idx_inc;
  logic [DATA_WIDTH-1:0] rsum_fin;

  assign rx_ready = (state_q != S_VERIFY) && (state_q != S_CHECK);
  assign accept   = rx_valid && rx_ready;
  assign idx_inc  = idx_q + CW'(1);
  assign rsum_fin = rsum_q + ram_rdata;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        counting, timeout;

  // Only waiting-for-byte states count; any accepted byte restarts the window.
  assign counting = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout  = counting && !accept && ((tmo_q + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign tmo_d    = (counting && !accept) ? tmo_q + 32'd1 : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    csum_d    = csum_q;
    rsum_d    = rsum_q;
    rd_pend_d = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    halt_d    = halt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'b00;
          halt_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (rx_data == '0 || rx_data > DEPTH_D) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            code_d  = 2'b01;
          end else begin
            state_d = S_DATA;
            len_d   = rx_data[CW-1:0];
            idx_d   = '0;
            sum_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_WIDTH-1:0];
          wdata_d = rx_data;
          sum_d   = sum_q + rx_data;
          idx_d   = idx_inc;
          if (idx_inc == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          csum_d = rx_data;
          if (rx_data != sum_q) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            code_d  = 2'b10;
          end else begin
            state_d = S_VERIFY;
            idx_d   = '0;
            rsum_d  = '0;
            addr_d  = '0;
          end
        end
      end
      // addr_q holds the address being read; ram_rdata lags it by one cycle.
      S_VERIFY: begin
        rd_pend_d = 1'b1;
        if (rd_pend_q) rsum_d = rsum_fin;
        if (idx_inc == len_q) begin
          state_d = S_CHECK;
        end else begin
          idx_d  = idx_inc;
          addr_d = idx_inc[ADDR_WIDTH-1:0];
        end
      end
      S_CHECK: begin
        rsum_d = rsum_fin;
        busy_d = 1'b0;
        if (rsum_fin == csum_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          halt_d  = 1'b0;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    if (timeout) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      code_d  = 2'b00;
      we_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      csum_q    <= '0;
      rsum_q    <= '0;
      rd_pend_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      halt_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      csum_q    <= csum_d;
      rsum_q    <= rsum_d;
      rd_pend_q <= rd_pend_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      halt_q    <= halt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign ram_we      = we_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign cpu_halt    = halt_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign load_error  = err_q;
  assign error_code  = code_q;

endmodule
